// File: rtl/imm_gen_pipe.sv
// RV32I/RV64I immediate generator with a registered two-entry output buffer
// (output register plus skid) so that in_ready comes straight from a flop.
module imm_gen_pipe #(
  parameter int XLEN      = 32,
  parameter bit EN_TARGET = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal,
  output logic [XLEN-1:0] out_target,
  output logic [XLEN-1:0] out_pc
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_SH   = 3'd6;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc;
  } entry_t;

  function automatic logic signed [XLEN-1:0] sext32(input logic signed [31:0] v);
    sext32 = v;
  endfunction

  function automatic entry_t decode(input logic [31:0] instr, input logic [XLEN-1:0] pc);
    entry_t                 e;
    logic signed [XLEN-1:0] imm;
    logic [5:0]             shamt;
    logic                   wide_bit;
    e        = '0;
    imm      = '0;
    // shamt[5] only exists on RV64; on RV32 a set instr[25] is malformed
    wide_bit = (XLEN == 64) & instr[25];
    shamt    = {wide_bit, instr[24:20]};
    case (instr[6:0])
      OP_LUI, OP_AUIPC: begin
        imm   = sext32({instr[31:12], 12'b0});
        e.fmt = FMT_U;
      end
      OP_JAL: begin
        imm   = sext32({{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0});
        e.fmt = FMT_J;
      end
      OP_BRANCH: begin
        imm   = sext32({{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0});
        e.fmt = FMT_B;
      end
      OP_STORE: begin
        imm   = sext32({{20{instr[31]}}, instr[31:25], instr[11:7]});
        e.fmt = FMT_S;
      end
      OP_LOAD, OP_JALR: begin
        imm   = sext32({{20{instr[31]}}, instr[31:20]});
        e.fmt = FMT_I;
      end
      OP_IMM: begin
        if (instr[14:12] == 3'b001) begin
          imm       = XLEN'(shamt);
          e.fmt     = FMT_SH;
          e.illegal = (instr[31:26] != 6'b0) | ((XLEN == 32) & instr[25]);
        end else if (instr[14:12] == 3'b101) begin
          imm       = XLEN'(shamt);
          e.fmt     = FMT_SH;
          e.illegal = !((instr[31:26] == 6'b000000) || (instr[31:26] == 6'b010000))
                      | ((XLEN == 32) & instr[25]);
        end else begin
          imm   = sext32({{20{instr[31]}}, instr[31:20]});
          e.fmt = FMT_I;
        end
      end
      default: e.fmt = FMT_NONE;
    endcase
    e.imm    = imm;
    e.pc     = pc;
    e.target = EN_TARGET ? (pc + imm) : '0;
    return e;
  endfunction

  entry_t dec_p0;
  entry_t out_p1;
  entry_t skid_p1;
  logic   vld_p1;
  logic   skid_vld_p1;
  logic   rdy_p1;
  logic   accept;
  logic   drain;
  logic   skid_vld_nxt;

  // ---- stage p0: combinational decode of the offered word
  assign dec_p0 = decode(in_instr, in_pc);
  assign accept = in_valid & rdy_p1 & ~flush;
  assign drain  = ~vld_p1 | out_ready;

  // accept implies the skid is empty, so a drain always leaves it empty
  assign skid_vld_nxt = drain ? 1'b0 : (skid_vld_p1 | accept);

  // ---- stage p1: output register and skid entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
      rdy_p1      <= 1'b0;
      out_p1      <= '0;
      skid_p1     <= '0;
    end else if (flush) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
      rdy_p1      <= 1'b1;
    end else begin
      if (drain) begin
        if (skid_vld_p1) begin
          out_p1 <= skid_p1;
          vld_p1 <= 1'b1;
        end else begin
          vld_p1 <= accept;
          if (accept) out_p1 <= dec_p0;
        end
      end
      if (accept && !drain) skid_p1 <= dec_p0;
      skid_vld_p1 <= skid_vld_nxt;
      rdy_p1      <= ~skid_vld_nxt;
    end
  end

  assign in_ready    = rdy_p1;
  assign out_valid   = vld_p1;
  assign out_imm     = out_p1.imm;
  assign out_fmt     = out_p1.fmt;
  assign out_illegal = out_p1.illegal;
  assign out_target  = out_p1.target;
  assign out_pc      = out_p1.pc;

endmodule
